bram_arbiter: RTL and testbench
===============================

// Module: bram_arbiter
// PURPOSE
//  Shares the single-port block RAM between the instruction-fetch and data (load/store) ports of the OTTER core.
//  Accepts one request per port using a valid/ready handshake, grants one request at a time and drives the RAM control signals.
//  Returns read data, or a write acknowledge, one cycle after the grant.
//  Sits between the multicycle control unit's memory interface and the block RAM instance.
// PARAMETERS
//  RAM_ADDR_WIDTH  13  word-address width of the RAM (2**13 words x 32b = 32KB)
//  RAM_BUS_WIDTH   32  RAM data width; byte-enable width is RAM_BUS_WIDTH/8
// PORTS
//  clk          in   1    system clock; all state changes on the rising edge
//  rst_n        in   1    reset, asynchronous, active-low
//  i_req_valid  in   1    fetch request pending
//  i_req_ready  out  1    fetch request accepted this cycle
//  i_req_addr   in   32   fetch byte address; bits [1:0] are ignored
//  i_rsp_valid  out  1    1-cycle pulse: i_rsp_rdata/i_rsp_err are valid
//  i_rsp_rdata  out  32   fetched word
//  i_rsp_err    out  1    address out of range
//  d_req_valid  in   1    load/store request pending
//  d_req_ready  out  1    data request accepted this cycle
//  d_req_we     in   4    byte write enables; 4'b0000 means read
//  d_req_addr   in   32   data byte address; bits [1:0] are ignored
//  d_req_wdata  in   32   store data, already byte-lane aligned
//  d_rsp_valid  out  1    1-cycle pulse: read data, or acknowledge of a write
//  d_rsp_rdata  out  32   loaded word (0 for writes)
//  d_rsp_err    out  1    address out of range
//  ram_rd_n     out  1    RAM read strobe, active-low (0 = read this edge)
//  ram_we       out  4    RAM byte write enables
//  ram_addr     out  13   RAM word address = req_addr[RAM_ADDR_WIDTH+1:2]
//  ram_wdata    out  32   RAM write data
//  ram_rdata    in   32   RAM registered read output
// BEHAVIOUR
//  - FSM states:
//    - IDLE: ready may be asserted.
//    - RESP: one cycle, response is driven. RESP always returns to IDLE.
//  - Grant, in IDLE only:
//    - At most one of i_req_ready/d_req_ready is high.
//    - Ready is combinational from valid and the arbitration state.
//    - Handshake = valid & ready. It moves the FSM to RESP and latches the grantee and err.
//  - RAM drive, grant cycle only:
//    - ram_addr, ram_wdata and ram_we come combinationally from the winner.
//    - ram_rd_n = 0 for reads.
//    - Idle or RESP cycle: ram_rd_n = 1, ram_we = 0, ram_addr/ram_wdata hold 0.
//  - Latency: response in the cycle after the handshake.
//    - x_rsp_rdata = ram_rdata.
//    - Max throughput: 1 transaction per 2 cycles. Ready is low in RESP.
//  - The fetch port never writes. i_req_* has no write enable; ram_we = 0 on every fetch.
//  - Range check: addr[31:RAM_ADDR_WIDTH+2] != 0 is an error.
//    - The request is still handshaken, but ram_rd_n stays 1 and ram_we stays 0.
//    - Next cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0.
//  - Simultaneous valid: resolved by the arbitration policy (CONFIGURATION).
//  - Requesters hold valid/addr/wdata stable until ready. The arbiter does not register requests.
//  - A deasserted valid before ready is permitted. That request is simply not served.
//  - Reset (rst_n=0, any time, including RESP):
//    - FSM goes to IDLE; all *_ready, *_rsp_valid and *_rsp_err = 0; rsp_rdata = 0.
//    - ram_rd_n = 1, ram_we = 0; RR pointer = fetch-preferred.
//    - An in-flight response is discarded. A write granted in the same cycle as reset assertion is not guaranteed.
// CONFIGURATION
//  BRAM_ARB_RR_EN defined:
//    - Round-robin over the two ports. A 1-bit last_grant register is updated on each handshake.
//    - On a tie, the port not granted last wins. After reset, fetch wins the first tie.
//  BRAM_ARB_RR_EN undefined:
//    - Fixed priority, data port over fetch port. No last_grant register.
// STRUCTURE
//  - Package bram_arb_pkg holds:
//    - typedef enum logic {IDLE, RESP} arb_state_t
//    - typedef enum logic {GNT_I, GNT_D} grant_t
//    - localparam BE_W = RAM_BUS_WIDTH/8
//  - One sub-module: bram_arb_pick (combinational grant select, holds the RR/fixed ifdef).
// TESTING
//  1. Reset: rst_n=0 with i/d valid=1 -> all ready=0, rsp_valid=0, ram_rd_n=1, ram_we=0.
//  2. Fetch of word at 0x0000_0010 (RAM[4]=0xDEAD_BEEF)
//     -> grant cycle: ram_addr=4, ram_rd_n=0.
//     -> next cycle: i_rsp_valid=1, i_rsp_rdata=0xDEAD_BEEF, i_rsp_err=0.
//  3. Store we=4'b0100, addr=0x20, wdata=0x00AB_0000, then load 0x20
//     -> d_rsp_valid for the store; load returns only byte 2 changed (0xAB).
//  4. Both valid for 4 transactions
//     -> RR_EN: grants I,D,I,D.
//     -> without RR_EN: grants D,D,D,D; fetch starves while d_req_valid stays high.
//  5. d_req_addr=0x0000_8000 (first byte past 32KB), we=4'hF
//     -> ram_we stays 0; next cycle d_rsp_valid=1, d_rsp_err=1; RAM contents unchanged.
//  6. rst_n pulsed low during RESP of a fetch -> i_rsp_valid=0 immediately; FSM in IDLE after release.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types and sizing for the block-RAM arbiter.
//   RAM_ADDR_WIDTH : word-address width of the RAM (8K words x 32b)
//   RAM_BUS_WIDTH  : RAM data width
//   BE_W           : byte-enable width
//   arb_state_t    : IDLE (may grant) / RESP (response cycle)
//   grant_t        : which port owns the current transaction
package bram_arb_pkg;

    localparam int unsigned RAM_ADDR_WIDTH = 13;
    localparam int unsigned RAM_BUS_WIDTH  = 32;
    localparam int unsigned BE_W           = RAM_BUS_WIDTH / 8;
    localparam int unsigned REQ_ADDR_W     = 32;

    typedef enum logic {IDLE, RESP} arb_state_t;
    typedef enum logic {GNT_I, GNT_D} grant_t;

endpackage

// File: rtl/bram_arb_if.sv
// Core-side request/response bundle for the fetch (i_*) and data (d_*) ports.
//   master : the core (drives requests, receives ready/responses)
//   slave  : the arbiter
interface bram_arb_if;
    import bram_arb_pkg::*;

    logic                      i_req_valid;
    logic                      i_req_ready;
    logic [REQ_ADDR_W-1:0]     i_req_addr;
    logic                      i_rsp_valid;
    logic [RAM_BUS_WIDTH-1:0]  i_rsp_rdata;
    logic                      i_rsp_err;

    logic                      d_req_valid;
    logic                      d_req_ready;
    logic [BE_W-1:0]           d_req_we;
    logic [REQ_ADDR_W-1:0]     d_req_addr;
    logic [RAM_BUS_WIDTH-1:0]  d_req_wdata;
    logic                      d_rsp_valid;
    logic [RAM_BUS_WIDTH-1:0]  d_rsp_rdata;
    logic                      d_rsp_err;

    modport master (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_rsp_valid, i_rsp_rdata, i_rsp_err,
        output d_req_valid, d_req_we, d_req_addr, d_req_wdata,
        input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
    );

    modport slave (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_rsp_valid, i_rsp_rdata, i_rsp_err,
        input  d_req_valid, d_req_we, d_req_addr, d_req_wdata,
        output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
    );

endinterface

// File: rtl/bram_arb_pick.sv
// Combinational grant select between fetch and data ports.
//   en          : arbiter may grant this cycle (IDLE, out of reset)
//   i/d_valid   : pending requests
//   last_grant  : previous winner (only with BRAM_ARB_RR_EN)
//   gnt_i_c/d_c : one-hot-or-zero grant
// BRAM_ARB_RR_EN defined: round-robin on ties; undefined: data over fetch.
module bram_arb_pick
    import bram_arb_pkg::*;
(
    input  logic   en,
    input  logic   i_valid,
    input  logic   d_valid,
`ifdef BRAM_ARB_RR_EN
    input  grant_t last_grant,
`endif
    output logic   gnt_i_c,
    output logic   gnt_d_c
);

    always_comb begin
        gnt_i_c = 1'b0;
        gnt_d_c = 1'b0;
        if (en) begin
`ifdef BRAM_ARB_RR_EN
            // On a tie the port not served last wins.
            if (i_valid && d_valid) begin
                if (last_grant == GNT_I) gnt_d_c = 1'b1;
                else                     gnt_i_c = 1'b1;
            end else begin
                gnt_i_c = i_valid;
                gnt_d_c = d_valid;
            end
`else
            gnt_d_c = d_valid;
            gnt_i_c = i_valid && !d_valid;
`endif
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one single-port block RAM between the OTTER fetch and data ports.
// One transaction at a time: grant cycle drives the RAM, next cycle returns
// the response. Out-of-range addresses are accepted but flagged with err.
//   clk, rst_n : clock, async active-low reset
//   bus        : fetch/data request-response bundle (slave side)
//   ram_*      : RAM control/data; ram_rdata is the RAM's registered output
// Optional macro: BRAM_ARB_RR_EN selects round-robin instead of fixed priority.
module bram_arbiter
    import bram_arb_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    bram_arb_if.slave                 bus,
    output logic                      ram_rd_n,
    output logic [BE_W-1:0]           ram_we,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [RAM_BUS_WIDTH-1:0]  ram_wdata,
    input  logic [RAM_BUS_WIDTH-1:0]  ram_rdata
);

    localparam int unsigned HI_LSB = RAM_ADDR_WIDTH + 2;

    arb_state_t state;
    grant_t     gnt_q;
    logic       err_q;
    logic       wr_q;
`ifdef BRAM_ARB_RR_EN
    grant_t     last_grant;
`endif

    logic                   gnt_i_c, gnt_d_c, hs_c;
    logic [REQ_ADDR_W-1:0]  win_addr_c;
    logic                   win_err_c, ram_ok_c;
    logic                   unused_addr_bits;

    // Ready is forced low while reset is asserted.
    bram_arb_pick u_pick (
        .en         (state == IDLE && rst_n),
        .i_valid    (bus.i_req_valid),
        .d_valid    (bus.d_req_valid),
`ifdef BRAM_ARB_RR_EN
        .last_grant (last_grant),
`endif
        .gnt_i_c    (gnt_i_c),
        .gnt_d_c    (gnt_d_c)
    );

    assign bus.i_req_ready = gnt_i_c;
    assign bus.d_req_ready = gnt_d_c;
    assign hs_c            = gnt_i_c || gnt_d_c;

    // Winner's address and range check.
    assign win_addr_c       = gnt_d_c ? bus.d_req_addr : bus.i_req_addr;
    assign win_err_c        = |win_addr_c[REQ_ADDR_W-1:HI_LSB];
    assign ram_ok_c         = hs_c && !win_err_c;
    assign unused_addr_bits = ^win_addr_c[1:0];

    // RAM is driven only on a valid, in-range grant; the fetch port never writes.
    assign ram_addr  = ram_ok_c ? win_addr_c[HI_LSB-1:2] : '0;
    assign ram_we    = (ram_ok_c && gnt_d_c) ? bus.d_req_we : '0;
    assign ram_wdata = (ram_ok_c && gnt_d_c) ? bus.d_req_wdata : '0;
    assign ram_rd_n  = !(ram_ok_c && (gnt_i_c || bus.d_req_we == '0));

    // Arbiter state: latch grantee/err/write on handshake, respond for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt_q <= GNT_I;
            err_q <= 1'b0;
            wr_q  <= 1'b0;
`ifdef BRAM_ARB_RR_EN
            last_grant <= GNT_D;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (hs_c) begin
                        state <= RESP;
                        gnt_q <= gnt_d_c ? GNT_D : GNT_I;
                        err_q <= win_err_c;
                        wr_q  <= gnt_d_c && (bus.d_req_we != '0);
`ifdef BRAM_ARB_RR_EN
                        last_grant <= gnt_d_c ? GNT_D : GNT_I;
`endif
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Responses decode straight from registered state; data comes from the RAM's output register.
    assign bus.i_rsp_valid = (state == RESP) && (gnt_q == GNT_I);
    assign bus.d_rsp_valid = (state == RESP) && (gnt_q == GNT_D);
    assign bus.i_rsp_err   = bus.i_rsp_valid && err_q;
    assign bus.d_rsp_err   = bus.d_rsp_valid && err_q;
    assign bus.i_rsp_rdata = (bus.i_rsp_valid && !err_q) ? ram_rdata : '0;
    assign bus.d_rsp_rdata = (bus.d_rsp_valid && !err_q && !wr_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed testbench for bram_arbiter with a behavioural byte-enabled RAM.
module tb_bram_arbiter;
    import bram_arb_pkg::*;

    logic                      clk;
    logic                      rst_n;
    logic                      ram_rd_n;
    logic [BE_W-1:0]           ram_we;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic [RAM_BUS_WIDTH-1:0]  ram_wdata;
    logic [RAM_BUS_WIDTH-1:0]  ram_rdata;

    logic [31:0] mem [0:(1<<RAM_ADDR_WIDTH)-1];

    int n_vec = 0;
    int n_err = 0;

    bram_arb_if bus ();

    bram_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ram_rd_n  (ram_rd_n),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM, registered read output.
    always @(posedge clk) begin
        if (!ram_rd_n) ram_rdata <= mem[ram_addr];
        for (int b = 0; b < 4; b++)
            if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic i_xact(input string tag, input logic [31:0] addr,
                          input logic exp_rd_n, input logic [31:0] exp_rdata, input logic exp_err);
        @(posedge clk); #1;
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = addr;
        @(negedge clk);
        chk({tag, ".i_ready"}, 32'(bus.i_req_ready), 32'd1);
        chk({tag, ".d_ready"}, 32'(bus.d_req_ready), 32'd0);
        chk({tag, ".rd_n"},    32'(ram_rd_n), 32'(exp_rd_n));
        chk({tag, ".we"},      32'(ram_we), 32'd0);
        if (!exp_err) chk({tag, ".addr"}, 32'(ram_addr), 32'(addr[14:2]));
        @(posedge clk); #1;
        bus.i_req_valid = 1'b0;
        @(negedge clk);
        chk({tag, ".rsp_valid"}, 32'(bus.i_rsp_valid), 32'd1);
        chk({tag, ".rsp_rdata"}, bus.i_rsp_rdata, exp_rdata);
        chk({tag, ".rsp_err"},   32'(bus.i_rsp_err), 32'(exp_err));
    endtask

    task automatic d_xact(input string tag, input logic [3:0] we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] exp_we, input logic exp_rd_n,
                          input logic [31:0] exp_rdata, input logic exp_err);
        @(posedge clk); #1;
        bus.d_req_valid = 1'b1;
        bus.d_req_we    = we;
        bus.d_req_addr  = addr;
        bus.d_req_wdata = wdata;
        @(negedge clk);
        chk({tag, ".d_ready"}, 32'(bus.d_req_ready), 32'd1);
        chk({tag, ".i_ready"}, 32'(bus.i_req_ready), 32'd0);
        chk({tag, ".rd_n"},    32'(ram_rd_n), 32'(exp_rd_n));
        chk({tag, ".we"},      32'(ram_we), 32'(exp_we));
        if (exp_we != 4'd0) chk({tag, ".wdata"}, ram_wdata, wdata);
        if (!exp_err) chk({tag, ".addr"}, 32'(ram_addr), 32'(addr[14:2]));
        @(posedge clk); #1;
        bus.d_req_valid = 1'b0;
        bus.d_req_we    = 4'd0;
        @(negedge clk);
        chk({tag, ".rsp_valid"}, 32'(bus.d_rsp_valid), 32'd1);
        chk({tag, ".rsp_rdata"}, bus.d_rsp_rdata, exp_rdata);
        chk({tag, ".rsp_err"},   32'(bus.d_rsp_err), 32'(exp_err));
    endtask

    initial begin
        grant_t exp_g [4];
        grant_t obs_g;

        for (int k = 0; k < (1 << RAM_ADDR_WIDTH); k++) mem[k] = 32'h0;
        mem[0] = 32'hCAFE_0000;
        mem[4] = 32'hDEAD_BEEF;
        mem[8] = 32'h1122_3344;

`ifdef BRAM_ARB_RR_EN
        exp_g = '{GNT_I, GNT_D, GNT_I, GNT_D};
`else
        exp_g = '{GNT_D, GNT_D, GNT_D, GNT_D};
`endif

        // Reset with both ports requesting.
        rst_n = 1'b0;
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 32'h10;
        bus.d_req_valid = 1'b1;
        bus.d_req_we    = 4'd0;
        bus.d_req_addr  = 32'h20;
        bus.d_req_wdata = 32'h0;
        @(negedge clk); @(negedge clk);
        chk("rst.i_ready",   32'(bus.i_req_ready), 32'd0);
        chk("rst.d_ready",   32'(bus.d_req_ready), 32'd0);
        chk("rst.i_rsp_v",   32'(bus.i_rsp_valid), 32'd0);
        chk("rst.d_rsp_v",   32'(bus.d_rsp_valid), 32'd0);
        chk("rst.d_rsp_err", 32'(bus.d_rsp_err), 32'd0);
        chk("rst.rd_n",      32'(ram_rd_n), 32'd1);
        chk("rst.we",        32'(ram_we), 32'd0);
        bus.i_req_valid = 1'b0;
        bus.d_req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Fetch, store, load-back.
        i_xact("fetch10", 32'h10, 1'b0, 32'hDEAD_BEEF, 1'b0);
        d_xact("store20", 4'b0100, 32'h20, 32'h00AB_0000, 4'b0100, 1'b1, 32'h0, 1'b0);
        d_xact("load20",  4'b0000, 32'h20, 32'h0, 4'b0000, 1'b0, 32'h11AB_3344, 1'b0);

        // Both ports valid for four transactions.
        @(posedge clk); #1;
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 32'h10;
        bus.d_req_valid = 1'b1;
        bus.d_req_we    = 4'd0;
        bus.d_req_addr  = 32'h20;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk($sformatf("tie%0d.onehot", t), 32'(bus.i_req_ready && bus.d_req_ready), 32'd0);
            obs_g = bus.d_req_ready ? GNT_D : GNT_I;
            chk($sformatf("tie%0d.grant", t), 32'(obs_g), 32'(exp_g[t]));
            @(negedge clk);
            if (exp_g[t] == GNT_I) begin
                chk($sformatf("tie%0d.i_rsp", t), bus.i_rsp_rdata, 32'hDEAD_BEEF);
                chk($sformatf("tie%0d.i_v", t),   32'(bus.i_rsp_valid), 32'd1);
            end else begin
                chk($sformatf("tie%0d.d_rsp", t), bus.d_rsp_rdata, 32'h11AB_3344);
                chk($sformatf("tie%0d.d_v", t),   32'(bus.d_rsp_valid), 32'd1);
            end
            chk($sformatf("tie%0d.ready_resp", t), 32'(bus.i_req_ready || bus.d_req_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.i_req_valid = 1'b0;
        bus.d_req_valid = 1'b0;

        // Out-of-range store and fetch; RAM word 0 must be untouched.
        d_xact("oor_st", 4'hF, 32'h0000_8000, 32'hFFFF_FFFF, 4'h0, 1'b1, 32'h0, 1'b1);
        i_xact("oor_if", 32'h0001_0000, 1'b1, 32'h0, 1'b1);
        d_xact("load0",  4'h0, 32'h0, 32'h0, 4'h0, 1'b0, 32'hCAFE_0000, 1'b0);

        // Reset pulsed during a fetch response.
        @(posedge clk); #1;
        bus.i_req_valid = 1'b1;
        bus.i_req_addr  = 32'h10;
        @(negedge clk);
        chk("rstresp.grant", 32'(bus.i_req_ready), 32'd1);
        @(posedge clk); #1;
        bus.i_req_valid = 1'b0;
        #1;
        chk("rstresp.pre_v", 32'(bus.i_rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstresp.v",     32'(bus.i_rsp_valid), 32'd0);
        chk("rstresp.rdata", bus.i_rsp_rdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.i_req_valid = 1'b1;
        @(negedge clk);
        chk("rstresp.idle_ready", 32'(bus.i_req_ready), 32'd1);
        @(posedge clk); #1;
        bus.i_req_valid = 1'b0;
        @(negedge clk);
        chk("rstresp.rsp", bus.i_rsp_rdata, 32'hDEAD_BEEF);

        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
